// File: rtl/vga_pkg.sv
// vga_pkg: shared raster timing types, region decode and
// default 640x480@60 geometry for the VGA display path.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE,
        FP,
        SYNC,
        BP
    } region_e;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_H_640 = '{
        active: 640, fp: 16, sync: 96, bp: 48
    };
    localparam vga_timing_t VGA_V_480 = '{
        active: 480, fp: 10, sync: 2, bp: 33
    };

    function automatic int timing_total(vga_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    function automatic region_e region_of(int c, vga_timing_t t);
        region_e r;
        if (c < t.active)
            r = ACTIVE;
        else if (c < t.active + t.fp)
            r = FP;
        else if (c < t.active + t.fp + t.sync)
            r = SYNC;
        else
            r = BP;
        return r;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; count and its region
// are registered together so they never disagree.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FP_LEN     = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BP_LEN     = 48,
    localparam int TOTAL = ACTIVE_LEN + FP_LEN
                         + SYNC_LEN + BP_LEN,
    localparam int W     = $clog2(TOTAL)
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         clr,
    output logic [W-1:0] count,
    output region_e      region,
    output logic         wrap
);

    localparam vga_timing_t TIM = '{
        ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN
    };

    logic [W-1:0] r_count;
    logic [W-1:0] w_next;
    region_e      r_region;

    assign wrap = step && (r_count == W'(TOTAL - 1));

    always_comb begin
        w_next = r_count;
        if (wrap)
            w_next = '0;
        else if (step)
            w_next = r_count + W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_region <= ACTIVE;
        end else if (clr) begin
            r_count  <= '0;
            r_region <= ACTIVE;
        end else begin
            r_count  <= w_next;
            r_region <= region_of(int'(w_next), TIM);
        end
    end

    assign count  = r_count;
    assign region = r_region;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster generator with
// pixel clock-enable, lookahead coordinates and frame count.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = VGA_H_640.active,
    parameter int H_FP      = VGA_H_640.fp,
    parameter int H_SYNC    = VGA_H_640.sync,
    parameter int H_BP      = VGA_H_640.bp,
    parameter int V_ACTIVE  = VGA_V_480.active,
    parameter int V_FP      = VGA_V_480.fp,
    parameter int V_SYNC    = VGA_V_480.sync,
    parameter int V_BP      = VGA_V_480.bp,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int LAT       = 1,
    parameter int FCNT_W    = 8,
    localparam int H_TOTAL = H_ACTIVE + H_FP
                           + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP
                           + V_SYNC + V_BP,
    localparam int XW = $clog2(H_TOTAL),
    localparam int YW = $clog2(V_TOTAL)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic              pix_ce,
    output logic              clk2,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic              req,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              sync,
    output logic              sof,
    output logic              eol,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int DW = $clog2(CLK_DIV);

    logic [DW-1:0]     r_div;
    logic              r_pix_ce;
    logic              r_clk2;
    logic              r_run;
    logic              r_sof;
    logic              r_eol;
    logic              r_wrapped;
    logic [FCNT_W-1:0] r_fcnt;

    logic          w_div_last;
    logic          w_step;
    logic          w_clr;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    region_e       w_h_region;
    region_e       w_v_region;
    logic          w_hwrap;
    logic          w_vwrap;
    logic [2:0]    w_d0;
    logic [2:0]    w_dl_out;

    assign w_div_last = (r_div == DW'(CLK_DIV - 1));
    assign w_step     = r_pix_ce && en;
    assign w_clr      = !en;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h (
        .clk    (clk),
        .reset  (reset),
        .step   (w_step),
        .clr    (w_clr),
        .count  (w_x),
        .region (w_h_region),
        .wrap   (w_hwrap)
    );

    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v (
        .clk    (clk),
        .reset  (reset),
        .step   (w_hwrap),
        .clr    (w_clr),
        .count  (w_y),
        .region (w_v_region),
        .wrap   (w_vwrap)
    );

    // pix_ce/sof/eol are registered off the divider so they
    // line up with the clk in which the counters advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div     <= '0;
            r_pix_ce  <= 1'b0;
            r_clk2    <= 1'b0;
            r_run     <= 1'b0;
            r_sof     <= 1'b0;
            r_eol     <= 1'b0;
            r_wrapped <= 1'b0;
            r_fcnt    <= '0;
        end else if (!en) begin
            r_div     <= '0;
            r_pix_ce  <= 1'b0;
            r_clk2    <= 1'b0;
            r_run     <= 1'b0;
            r_sof     <= 1'b0;
            r_eol     <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            r_div    <= w_div_last ? '0 : r_div + DW'(1);
            r_pix_ce <= w_div_last;
            r_clk2   <= (r_div < DW'(CLK_DIV / 2));
            r_run    <= 1'b1;
            r_sof    <= w_div_last && (w_x == '0)
                        && (w_y == '0);
            r_eol    <= w_div_last
                        && (w_x == XW'(H_TOTAL - 1));
            if (w_step) begin
                r_wrapped <= w_vwrap;
                if (r_wrapped)
                    r_fcnt <= r_fcnt + FCNT_W'(1);
            end
        end
    end

    // Stage 0: {hsync, vsync, visible} of the issue coordinate.
    assign w_d0 = {
        r_run && (w_h_region == SYNC),
        r_run && (w_v_region == SYNC),
        r_run && (w_h_region == ACTIVE)
              && (w_v_region == ACTIVE)
    };

    generate
        if (LAT > 0) begin : g_dl
            logic [2:0] r_dl [LAT];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < LAT; i++)
                        r_dl[i] <= '0;
                end else if (!en) begin
                    for (int i = 0; i < LAT; i++)
                        r_dl[i] <= '0;
                end else if (w_step) begin
                    r_dl[0] <= w_d0;
                    for (int i = 1; i < LAT; i++)
                        r_dl[i] <= r_dl[i-1];
                end
            end

            assign w_dl_out = r_dl[LAT-1];
        end else begin : g_nodl
            assign w_dl_out = w_d0;
        end
    endgenerate

    assign pix_ce    = r_pix_ce;
    assign clk2      = r_clk2;
    assign x         = w_x;
    assign y         = w_y;
    assign req       = w_d0[0];
    assign hsync     = w_dl_out[2] ? HSYNC_POL : ~HSYNC_POL;
    assign vsync     = w_dl_out[1] ? VSYNC_POL : ~VSYNC_POL;
    assign blank     = w_dl_out[0];
    assign sync      = 1'b1;
    assign sof       = r_sof;
    assign eol       = r_eol;
    assign frame_cnt = r_fcnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of three generator
// configurations sharing one clock, reset and enable.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic en;
    int   cyc = 0;
    int   n_run = 0;
    int   n_fail = 0;

    logic       a_pce, a_clk2, a_req, a_hs, a_vs;
    logic       a_blank, a_sync, a_sof, a_eol;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;

    logic       b_pce, b_clk2, b_req, b_hs, b_vs;
    logic       b_blank, b_sync, b_sof, b_eol;
    logic [3:0] b_x, b_y;
    logic [7:0] b_fc;

    logic       c_pce, c_clk2, c_req, c_hs, c_vs;
    logic       c_blank, c_sync, c_sof, c_eol;
    logic [9:0] c_x, c_y;
    logic [7:0] c_fc;

    vga_timing_gen u_a (
        .clk(clk), .reset(reset), .en(en),
        .pix_ce(a_pce), .clk2(a_clk2),
        .x(a_x), .y(a_y), .req(a_req),
        .hsync(a_hs), .vsync(a_vs),
        .blank(a_blank), .sync(a_sync),
        .sof(a_sof), .eol(a_eol), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .LAT(3)
    ) u_b (
        .clk(clk), .reset(reset), .en(en),
        .pix_ce(b_pce), .clk2(b_clk2),
        .x(b_x), .y(b_y), .req(b_req),
        .hsync(b_hs), .vsync(b_vs),
        .blank(b_blank), .sync(b_sync),
        .sof(b_sof), .eol(b_eol), .frame_cnt(b_fc)
    );

    vga_timing_gen #(
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .CLK_DIV(4), .LAT(0)
    ) u_c (
        .clk(clk), .reset(reset), .en(en),
        .pix_ce(c_pce), .clk2(c_clk2),
        .x(c_x), .y(c_y), .req(c_req),
        .hsync(c_hs), .vsync(c_vs),
        .blank(c_blank), .sync(c_sync),
        .sof(c_sof), .eol(c_eol), .frame_cnt(c_fc)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, act, exp);
        end
    endtask

    // Default config: pixel rate, line period, hsync placement.
    int a_bad_pce = 0, t_apce = -1;
    int t_ax0 = 0, t_ax656 = 0, t_ahs = 0, t_aeol = 0;
    int a_d656 = 0, a_dhs = 0, a_hsw = 0, a_eolper = 0;
    logic [9:0] pa_x = '0;
    logic pa_hs = 1'b1, pa_eol = 1'b0;
    initial forever begin
        @(negedge clk);
        if (a_pce) begin
            if (t_apce >= 0 && cyc - t_apce != 2)
                a_bad_pce++;
            t_apce = cyc;
        end
        if (a_x == 0 && pa_x == 799)
            t_ax0 = cyc;
        if (a_x == 656 && pa_x == 655) begin
            t_ax656 = cyc;
            a_d656 = cyc - t_ax0;
        end
        if (!a_hs && pa_hs) begin
            t_ahs = cyc;
            a_dhs = cyc - t_ax656;
        end
        if (a_hs && !pa_hs)
            a_hsw = cyc - t_ahs;
        if (a_eol && !pa_eol) begin
            a_eolper = cyc - t_aeol;
            t_aeol = cyc;
        end
        pa_x = a_x;
        pa_hs = a_hs;
        pa_eol = a_eol;
    end

    // Small config, LAT=3: lookahead, vsync lines, frames.
    int b_npce = 0, b_req_n = 0, b_nbr = 0;
    int b_bad_lat = 0, b_bad_area = 0;
    int t_bvs = 0, b_vs_w = 0, b_vs_x = -1, b_vs_y = -1;
    int t_beol = 0, t_bsof = 0, b_nsof = 0;
    int b_sof_per = 0, b_sof_eol = 0;
    int b_fc0 = -1, b_fc1 = -1;
    logic pb_req = 1'b0, pb_blank = 1'b0;
    logic pb_vs = 1'b1, pb_sof = 1'b0;
    initial forever begin
        @(negedge clk);
        if (b_pce)
            b_npce++;
        if (b_req && !pb_req)
            b_req_n = b_npce;
        if (b_blank && !pb_blank) begin
            b_nbr++;
            if (b_npce - b_req_n != 3)
                b_bad_lat++;
        end
        if ((b_req || b_blank) && b_y >= 6)
            b_bad_area++;
        if (!b_vs && pb_vs) begin
            t_bvs = cyc;
            b_vs_x = int'(b_x);
            b_vs_y = int'(b_y);
        end
        if (b_vs && !pb_vs)
            b_vs_w = cyc - t_bvs;
        if (pb_sof && b_nsof == 1)
            b_fc0 = int'(b_fc);
        if (pb_sof && b_nsof == 2)
            b_fc1 = int'(b_fc);
        if (b_eol)
            t_beol = cyc;
        if (b_sof) begin
            if (b_nsof > 0) begin
                b_sof_per = cyc - t_bsof;
                b_sof_eol = cyc - t_beol;
            end
            t_bsof = cyc;
            b_nsof++;
        end
        pb_req = b_req;
        pb_blank = b_blank;
        pb_vs = b_vs;
        pb_sof = b_sof;
    end

    // Inverted polarity, CLK_DIV=4.
    int c_bad_pce = 0, t_cpce = -1;
    int t_ceol = 0, c_eolper = 0;
    int t_chs = 0, c_hsw = 0;
    int t_c2 = 0, c_bad_c2 = 0, c_nc2 = 0;
    logic pc_hs = 1'b0, pc_eol = 1'b0, pc_c2 = 1'b0;
    initial forever begin
        @(negedge clk);
        if (c_pce) begin
            if (t_cpce >= 0 && cyc - t_cpce != 4)
                c_bad_pce++;
            t_cpce = cyc;
        end
        if (c_eol && !pc_eol) begin
            c_eolper = cyc - t_ceol;
            t_ceol = cyc;
        end
        if (c_hs && !pc_hs)
            t_chs = cyc;
        if (!c_hs && pc_hs)
            c_hsw = cyc - t_chs;
        if (c_clk2 && !pc_c2)
            t_c2 = cyc;
        if (!c_clk2 && pc_c2) begin
            c_nc2++;
            if (cyc - t_c2 != 2)
                c_bad_c2++;
        end
        pc_hs = c_hs;
        pc_eol = c_eol;
        pc_c2 = c_clk2;
    end

    int t_en;
    int a_first, c_first, b_sof_d;
    int idle_pce, gap_pce, fc_keep;
    bit found;

    initial begin
        reset = 1'b0;
        en = 1'b0;
        #10 reset = 1'b1;
        idle_pce = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_pce || b_pce || c_pce)
                idle_pce++;
        end
        check("rst_pce", idle_pce, 0);
        check("rst_clk2", a_clk2, 0);
        check("rst_xy", {a_x, a_y}, 0);
        check("rst_req", a_req, 0);
        check("rst_sof_eol", {a_sof, a_eol}, 0);
        check("rst_fc", a_fc, 0);
        check("rst_blank", a_blank, 0);
        check("rst_sync", {a_sync, b_sync, c_sync}, 3'b111);
        check("rst_hs_vs", {a_hs, a_vs}, 2'b11);
        check("rst_hs_vs_pol", {c_hs, c_vs}, 2'b00);

        en = 1'b1;
        t_en = cyc;
        a_first = -1;
        c_first = -1;
        b_sof_d = -1;
        repeat (8) begin
            @(negedge clk);
            if (a_pce && a_first < 0)
                a_first = cyc - t_en;
            if (c_pce && c_first < 0)
                c_first = cyc - t_en;
            if (b_sof && b_sof_d < 0)
                b_sof_d = cyc - t_en;
        end
        check("first_pce_div2", a_first, 2);
        check("first_pce_div4", c_first, 4);
        check("first_sof", b_sof_d, 2);

        repeat (7000) @(negedge clk);

        check("a_pce_period", a_bad_pce, 0);
        check("a_eol_period", a_eolper, 1600);
        check("a_x0_to_x656", a_d656, 1312);
        check("a_hs_lat", a_dhs, 2);
        check("a_hs_width", a_hsw, 192);

        check("c_pce_period", c_bad_pce, 0);
        check("c_eol_period", c_eolper, 3200);
        check("c_hs_high", c_hsw, 384);
        check("c_vs_idle", c_vs, 0);
        check("c_clk2_high", c_bad_c2, 0);
        check("c_clk2_seen", c_nc2 > 0, 1);

        check("b_blank_lat", b_bad_lat, 0);
        check("b_blank_rises", b_nbr >= 6, 1);
        check("b_area", b_bad_area, 0);
        check("b_vs_x", b_vs_x, 3);
        check("b_vs_y", b_vs_y, 7);
        check("b_vs_width", b_vs_w, 64);
        check("b_sof_period", b_sof_per, 352);
        check("b_eol_to_sof", b_sof_eol, 2);
        check("b_fc_sof1", b_fc0, 0);
        check("b_fc_sof2", b_fc1, 1);

        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (b_x == 4'd5 && b_y == 4'd3)
                found = 1'b1;
        end
        check("gap_reach", found, 1);
        fc_keep = int'(b_fc);
        en = 1'b0;
        @(negedge clk);
        check("gap_blank", {b_blank, b_req}, 0);
        check("gap_sync", {b_hs, b_vs}, 2'b11);
        check("gap_clk2", b_clk2, 0);
        gap_pce = 0;
        repeat (4) begin
            @(negedge clk);
            if (b_pce)
                gap_pce++;
        end
        check("gap_pce", gap_pce, 0);
        check("gap_xy", {b_x, b_y}, 0);

        en = 1'b1;
        t_en = cyc;
        b_sof_d = -1;
        for (int i = 0; i < 8 && b_sof_d < 0; i++) begin
            @(negedge clk);
            if (b_sof)
                b_sof_d = cyc - t_en;
        end
        check("gap_sof_dly", b_sof_d, 2);
        @(negedge clk);
        check("gap_fc_keep", b_fc, fc_keep);

        $display("[TB] %0d tests run, %0d failed",
                 n_run, n_fail);
        $finish;
    end

endmodule
